// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the calculator scheduler control unit: state codes
// (which double as the debug LED encoding), opcode constants and the result
// register source selects used by the datapath muxes.
package calc_ctrl_pkg;

  // State codes are fixed because cs is exported to the board LEDs.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_DISPATCH  = 4'd2,
    S_WAIT_CALC = 4'd3,
    S_WAIT_DIV  = 4'd4,
    S_WAIT_MULT = 4'd5,
    S_LATCH     = 4'd6,
    S_DONE      = 4'd7
  } state_t;

  // Opcodes 0-3 go straight to the small calculator; 6-7 are illegal.
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MULT = 3'd5;

  // out_l source select.
  localparam logic [1:0] SEL_L_CALC = 2'd0;
  localparam logic [1:0] SEL_L_QUO  = 2'd1;
  localparam logic [1:0] SEL_L_PROD = 2'd2;
  localparam logic [1:0] SEL_L_ZERO = 2'd3;

  // out_h source select.
  localparam logic SEL_H_REM  = 1'b0;
  localparam logic SEL_H_PROD = 1'b1;

  // Opcodes above multiply have no execution unit behind them.
  function automatic logic isIllegalOp(input logic [2:0] op);
    return (op > OP_MULT);
  endfunction

endpackage

// File: rtl/calc_sched_ctrl.sv
// Control unit for the 4-bit calculator datapath. Accepts one job from the
// user FSM, loads the operands, starts the selected execution unit, waits for
// it (with a timeout for the handshaked units), then steers the result into
// out_h/out_l and reports done/err until the requester drops go.
module calc_sched_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic [2:0] i_op,
  input  logic       i_done_calc,
  input  logic       i_done_div,
  output logic       o_en_x,
  output logic       o_en_y,
  output logic       o_go_calc,
  output logic       o_go_div,
  output logic       o_go_mult,
  output logic [1:0] o_op_calc,
  output logic       o_sel_h,
  output logic [1:0] o_sel_l,
  output logic       o_en_out_h,
  output logic       o_en_out_l,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_cs
);

  // The wait counter holds the number of WAIT cycles already spent; the
  // comparisons below look at the value it would take after this cycle, so
  // TIMEOUT is the number of WAIT cycles in which a done is still accepted and
  // the multiplier wait spans MULT_LAT cycles including DISPATCH.
  localparam logic [8:0] TIMEOUT_C   = 9'(TIMEOUT);
  localparam logic [8:0] MULT_EXIT_C = 9'(MULT_LAT - 1);

  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_cnt;
  logic       r_err;
  logic [8:0] w_cntNext;

  assign w_cntNext = {1'b0, r_cnt} + 9'd1;

  // State register, latched opcode, error flag and the wait counter advance
  // together so that every output can be decoded purely from registered state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_op  <= i_op;
            r_err <= 1'b0;
            if (isIllegalOp(i_op)) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_DISPATCH;
        end
        S_DISPATCH: begin
          r_cnt <= 8'd0;
          if (r_op == OP_DIV) begin
            r_state <= S_WAIT_DIV;
          end else if (r_op == OP_MULT) begin
            r_state <= (MULT_LAT <= 1) ? S_LATCH : S_WAIT_MULT;
          end else begin
            r_state <= S_WAIT_CALC;
          end
        end
        S_WAIT_CALC: begin
          if (i_done_calc) begin
            r_state <= S_LATCH;
          end else if (w_cntNext == TIMEOUT_C) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cntNext[7:0];
          end
        end
        S_WAIT_DIV: begin
          if (i_done_div) begin
            r_state <= S_LATCH;
          end else if (w_cntNext == TIMEOUT_C) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cntNext[7:0];
          end
        end
        S_WAIT_MULT: begin
          if (w_cntNext >= MULT_EXIT_C) begin
            r_state <= S_LATCH;
          end else begin
            r_cnt <= w_cntNext[7:0];
          end
        end
        S_LATCH: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!i_go) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode: strobes and selects depend only on the state and on
  // the opcode latched at acceptance, never on the live inputs.
  always_comb begin
    o_en_x     = 1'b0;
    o_en_y     = 1'b0;
    o_go_calc  = 1'b0;
    o_go_div   = 1'b0;
    o_go_mult  = 1'b0;
    o_sel_h    = SEL_H_REM;
    o_sel_l    = SEL_L_CALC;
    o_en_out_h = 1'b0;
    o_en_out_l = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_en_x = 1'b1;
        o_en_y = 1'b1;
      end
      S_DISPATCH: begin
        if (r_op == OP_DIV) begin
          o_go_div = 1'b1;
        end else if (r_op == OP_MULT) begin
          o_go_mult = 1'b1;
        end else begin
          o_go_calc = 1'b1;
        end
      end
      S_WAIT_MULT: begin
        o_go_mult = 1'b1;
      end
      S_LATCH: begin
        o_en_out_l = 1'b1;
        if (r_op == OP_DIV) begin
          o_en_out_h = 1'b1;
          o_sel_h    = SEL_H_REM;
          o_sel_l    = SEL_L_QUO;
        end else if (r_op == OP_MULT) begin
          o_en_out_h = 1'b1;
          o_sel_h    = SEL_H_PROD;
          o_sel_l    = SEL_L_PROD;
        end else begin
          o_sel_l    = SEL_L_CALC;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_done = 1'b0;
      end
    endcase
  end

  // The small-calculator opcode comes straight from the acceptance latch, so
  // it stays put for the whole job regardless of what op does afterwards.
  assign o_op_calc = r_op[1:0];
  assign o_err     = r_err;
  assign o_cs      = r_state;

endmodule
